// File: rtl/data_ram.sv
// rtl/data_ram.sv - byte/half/word data RAM with power-up clear sweep and 1- or 2-cycle responses
module data_ram #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DEPTH_WORDS  = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           data_in,
   output logic                  rsp_valid,
   output logic                  rsp_error,
   output logic [31:0]           data_out,
   output logic                  init_done
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic {INIT, READY} state_t;

   state_t           state, state_nx;
   logic [IDX_W-1:0] sweep_idx;
   logic             last_word;

   logic [1:0]       lane;
   logic [IDX_W-1:0] word_idx;
   logic             out_of_range;
   logic             req_error;
   logic             accept;
   logic             store_en;
   logic [3:0]       wr_strb;
   logic [31:0]      wr_data;
   logic [31:0]      rd_word;
   logic [31:0]      rd_shift;
   logic [31:0]      load_data;
   logic [31:0]      rsp_data_nx;

   logic [31:0]      mem [DEPTH_WORDS];

   logic             s1_valid, s1_error;
   logic [31:0]      s1_data;

   assign last_word = (sweep_idx == IDX_W'(DEPTH_WORDS - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= INIT;
         sweep_idx <= '0;
      end else begin
         state <= state_nx;
         if (state == INIT)
            sweep_idx <= sweep_idx + IDX_W'(1);
      end
   end

   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      init_done = 1'b0;
      case (state)
         INIT: begin
            if (last_word)
               state_nx = READY;
         end
         READY: begin
            req_ready = 1'b1;
            init_done = 1'b1;
         end
         default: state_nx = INIT;
      endcase
   end

   assign lane     = address[1:0];
   assign word_idx = address[IDX_W+1:2];

   // Any set address bit above the word index means the word lies past the array.
   generate
      if (ADDR_WIDTH > IDX_W + 2) begin : g_hi_bits
         assign out_of_range = |address[ADDR_WIDTH-1:IDX_W+2];
      end else begin : g_no_hi_bits
         assign out_of_range = 1'b0;
      end
   endgenerate

   assign req_error = (req_size == 2'b11)
                    | ((req_size == 2'b01) & address[0])
                    | ((req_size == 2'b10) & (|address[1:0]))
                    | out_of_range;

   assign accept   = req_valid & req_ready;
   assign store_en = accept & req_write & ~req_error;

   always_comb begin
      wr_strb = 4'b0000;
      wr_data = data_in;
      case (req_size)
         2'b00: begin
            wr_strb = 4'b0001 << lane;
            wr_data = {4{data_in[7:0]}};
         end
         2'b01: begin
            wr_strb = address[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{data_in[15:0]}};
         end
         2'b10:   wr_strb = 4'b1111;
         default: wr_strb = 4'b0000;
      endcase
   end

   // Memory has no reset: contents become defined only through the INIT sweep.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[sweep_idx] <= '0;
      end else if (store_en) begin
         for (int b = 0; b < 4; b++)
            if (wr_strb[b])
               mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end

   assign rd_word  = mem[word_idx];
   assign rd_shift = rd_word >> {lane, 3'b000};

   always_comb begin
      load_data = rd_word;
      case (req_size)
         2'b00:   load_data = req_unsigned ? {24'b0, rd_shift[7:0]}
                                           : {{24{rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   load_data = req_unsigned ? {16'b0, rd_shift[15:0]}
                                           : {{16{rd_shift[15]}}, rd_shift[15:0]};
         default: load_data = rd_word;
      endcase
   end

   assign rsp_data_nx = (req_write | req_error) ? 32'b0 : load_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_error <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= accept;
         s1_error <= accept & req_error;
         s1_data  <= accept ? rsp_data_nx : 32'b0;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic        s2_valid, s2_error;
         logic [31:0] s2_data;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               s2_valid <= 1'b0;
               s2_error <= 1'b0;
               s2_data  <= '0;
            end else begin
               s2_valid <= s1_valid;
               s2_error <= s1_error;
               s2_data  <= s1_data;
            end
         end
         assign rsp_valid = s2_valid;
         assign rsp_error = s2_error;
         assign data_out  = s2_data;
      end else begin : g_lat1
         assign rsp_valid = s1_valid;
         assign rsp_error = s1_error;
         assign data_out  = s1_data;
      end
   endgenerate

endmodule

// File: tb/tb_data_ram.sv
// tb/tb_data_ram.sv - self-checking bench for data_ram at read latencies 1 and 2
module tb_data_ram;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] data_in = '0;

   logic        ready1, valid1, error1, done1;
   logic [31:0] dout1;
   logic        ready2, valid2, error2, done2;
   logic [31:0] dout2;

   data_ram #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(1)) u_lat1 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(ready1),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .address(address), .data_in(data_in), .rsp_valid(valid1), .rsp_error(error1),
      .data_out(dout1), .init_done(done1));

   data_ram #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(2)) u_lat2 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(ready2),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .address(address), .data_in(data_in), .rsp_valid(valid2), .rsp_error(error2),
      .data_out(dout2), .init_done(done2));

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
   } rsp_t;

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] a;
      logic [31:0] d;
      logic        err;
      logic [31:0] exp;
   } vec_t;

   rsp_t q1[$];
   rsp_t q2[$];
   vec_t tbl[$];

   logic [7:0] ref_mem [DEPTH*4];

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Byte-array reference: little-endian memory, rules straight from the access definitions.
   function automatic void model(input logic wr, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] a, input logic [31:0] d,
                                 output logic err, output logic [31:0] rd);
      int n;
      err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
            || (a / 4 >= DEPTH);
      rd = '0;
      if (err) return;
      n = 1 << sz;
      for (int i = 0; i < n; i++) begin
         if (wr) ref_mem[a + i] = d[8*i +: 8];
         else    rd[8*i +: 8] = ref_mem[a + i];
      end
      if (!wr && !uns && n < 4 && rd[8*n-1])
         rd = rd | (32'hFFFF_FFFF << (8*n));
   endfunction

   function automatic void clear_model();
      for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
   endfunction

   task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic use_exp, input logic eerr, input logic [31:0] edata);
      logic        err;
      logic [31:0] rd;
      rsp_t        r;
      model(wr, sz, uns, a, d, err, rd);
      if (use_exp) begin
         err = eerr;
         rd  = edata;
      end
      r.err  = err;
      r.data = rd;
      r.due  = cyc + 1;
      q1.push_back(r);
      r.due  = cyc + 2;
      q2.push_back(r);
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      address      = a;
      data_in      = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] d, input logic err, input logic [31:0] exp);
      vec_t v;
      v.wr = wr; v.sz = sz; v.uns = uns; v.a = a; v.d = d; v.err = err; v.exp = exp;
      tbl.push_back(v);
   endtask

   task automatic wait_init(input string name);
      int n = 0;
      while (!(ready1 && ready2) && n < DEPTH + 10) begin
         chk({name, " init_done low"}, 32'(done1 | done2), 32'd0);
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, " sweep cycles"}, 32'(n), 32'(DEPTH));
      chk({name, " init_done lat1"}, 32'(done1), 32'd1);
      chk({name, " init_done lat2"}, 32'(done2), 32'd1);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, " req_ready"}, 32'(ready1 | ready2), 32'd0);
      chk({name, " init_done"}, 32'(done1 | done2), 32'd0);
      chk({name, " rsp_valid lat1"}, 32'(valid1), 32'd0);
      chk({name, " rsp_valid lat2"}, 32'(valid2), 32'd0);
      chk({name, " rsp_error"}, 32'(error1 | error2), 32'd0);
      chk({name, " data_out lat1"}, dout1, 32'd0);
      chk({name, " data_out lat2"}, dout2, 32'd0);
   endtask

   // Every cycle each DUT either returns the next due response or stays fully idle.
   always @(negedge clk) begin
      if (chk_en) begin
         if (q1.size() > 0 && q1[0].due == cyc) begin
            chk("lat1 rsp_valid", 32'(valid1), 32'd1);
            chk("lat1 rsp_error", 32'(error1), 32'(q1[0].err));
            chk("lat1 data_out", dout1, q1[0].data);
            void'(q1.pop_front());
         end else begin
            chk("lat1 idle rsp_valid", 32'(valid1), 32'd0);
            chk("lat1 idle rsp_error", 32'(error1), 32'd0);
            chk("lat1 idle data_out", dout1, 32'd0);
         end
         if (q2.size() > 0 && q2[0].due == cyc) begin
            chk("lat2 rsp_valid", 32'(valid2), 32'd1);
            chk("lat2 rsp_error", 32'(error2), 32'(q2[0].err));
            chk("lat2 data_out", dout2, q2[0].data);
            void'(q2.pop_front());
         end else begin
            chk("lat2 idle rsp_valid", 32'(valid2), 32'd0);
            chk("lat2 idle rsp_error", 32'(error2), 32'd0);
            chk("lat2 idle data_out", dout2, 32'd0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global timeout: got running, expected finished");
      $fatal(1);
   end

   initial begin
      clear_model();

      add(0, 2'd2, 0, 32'h10, 32'h0,          0, 32'h0000_0000);
      add(1, 2'd2, 0, 32'h04, 32'hA5A5_A5A5,  0, 32'h0000_0000);
      add(0, 2'd2, 0, 32'h04, 32'h0,          0, 32'hA5A5_A5A5);
      add(1, 2'd0, 0, 32'h09, 32'h0000_0080,  0, 32'h0000_0000);
      add(0, 2'd0, 0, 32'h09, 32'h0,          0, 32'hFFFF_FF80);
      add(0, 2'd0, 1, 32'h09, 32'h0,          0, 32'h0000_0080);
      add(0, 2'd2, 0, 32'h08, 32'h0,          0, 32'h0000_8000);
      add(0, 2'd1, 0, 32'h03, 32'h0,          1, 32'h0000_0000);
      add(1, 2'd2, 0, 32'h02, 32'hDEAD_BEEF,  1, 32'h0000_0000);
      add(1, 2'd3, 0, 32'h04, 32'h1234_5678,  1, 32'h0000_0000);
      add(0, 2'd2, 0, 32'h40, 32'h0,          1, 32'h0000_0000);
      add(1, 2'd2, 0, 32'h40, 32'h0000_0055,  1, 32'h0000_0000);
      add(1, 2'd1, 0, 32'h01, 32'h0000_BEEF,  1, 32'h0000_0000);
      add(0, 2'd2, 0, 32'h04, 32'h0,          0, 32'hA5A5_A5A5);
      add(0, 2'd2, 0, 32'h00, 32'h0,          0, 32'h0000_0000);
      add(1, 2'd2, 0, 32'h00, 32'h0000_0001,  0, 32'h0000_0000);
      add(1, 2'd2, 0, 32'h04, 32'h0000_0002,  0, 32'h0000_0000);
      add(1, 2'd2, 0, 32'h08, 32'h0000_0003,  0, 32'h0000_0000);
      add(0, 2'd2, 0, 32'h00, 32'h0,          0, 32'h0000_0001);
      add(0, 2'd2, 0, 32'h04, 32'h0,          0, 32'h0000_0002);
      add(0, 2'd2, 0, 32'h08, 32'h0,          0, 32'h0000_0003);
      add(1, 2'd1, 0, 32'h0A, 32'hFFFF_8001,  0, 32'h0000_0000);
      add(0, 2'd1, 0, 32'h0A, 32'h0,          0, 32'hFFFF_8001);
      add(0, 2'd1, 1, 32'h0A, 32'h0,          0, 32'h0000_8001);
      add(0, 2'd2, 0, 32'h08, 32'h0,          0, 32'h8001_0003);
      add(0, 2'd0, 0, 32'h0B, 32'h0,          0, 32'hFFFF_FF80);

      #2;
      check_reset_outputs("power-on reset");
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      wait_init("first");

      for (int i = 0; i < tbl.size(); i++)
         do_req(tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].d, 1'b1, tbl[i].err, tbl[i].exp);
      idle();
      idle();

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0)
            idle();
         else
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, DEPTH*4 + 3)), $urandom, 1'b0, 1'b0, 32'h0);
      end
      idle();
      idle();

      // Reset with two loads outstanding: nothing may come back and the sweep must rerun.
      do_req(1, 2'd2, 0, 32'h04, 32'h1111_2222, 1'b0, 1'b0, 32'h0);
      do_req(0, 2'd2, 0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h0);
      do_req(0, 2'd2, 0, 32'h04, 32'h0, 1'b0, 1'b0, 32'h0);
      chk_en = 1'b0;
      req_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("mid-flight reset");
      q1.delete();
      q2.delete();
      clear_model();
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      wait_init("rerun");
      do_req(0, 2'd2, 0, 32'h04, 32'h0, 1'b1, 1'b0, 32'h0000_0000);
      do_req(0, 2'd1, 1, 32'h06, 32'h0, 1'b1, 1'b0, 32'h0000_0000);
      idle();

      for (int i = 0; i < 10 && (q1.size() > 0 || q2.size() > 0); i++) idle();
      chk("outstanding responses lat1", 32'(q1.size()), 32'd0);
      chk("outstanding responses lat2", 32'(q2.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
